// File: rtl/riscv_tag_exception_ctrl.sv
// DIFT tag-violation trap controller: captures the first violating EX instruction and raises a trap request.
// Optional macro DIFT_EXC_COUNTER_EN adds a saturating 16-bit violation counter.
module riscv_tag_exception_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic        exception_i_tag,
  input  logic        check_s1_i_tag,
  input  logic        check_s2_i_tag,
  input  logic        check_d_i_tag,
  input  logic        operand_a_i_tag,
  input  logic        operand_b_i_tag,
  input  logic        result_i_tag,
  input  logic [31:0] pc_ex_i,
  input  logic [31:0] instr_ex_i,
  input  logic        tag_trap_ack_i,
  input  logic        tag_clear_i,
  output logic        tag_trap_req_o,
  output logic [31:0] tag_trap_pc_o,
  output logic [31:0] tag_trap_instr_o,
  output logic [2:0]  tag_trap_cause_o,
  output logic        halt_ex_o,
  output logic        tag_overflow_o,
  output logic [15:0] tag_exc_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HELD = 2'd2
  } state_t;

  state_t state, state_next;

  logic       violation;
  logic       capture;
  logic [2:0] cause;

  assign violation = ex_valid_i & exception_i_tag;
  assign capture   = (state == IDLE) & violation;
  assign cause     = {check_d_i_tag  & result_i_tag,
                      check_s2_i_tag & operand_b_i_tag,
                      check_s1_i_tag & operand_a_i_tag};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next     = state;
    tag_trap_req_o = 1'b0;
    halt_ex_o      = 1'b0;
    unique case (state)
      IDLE: if (violation) state_next = REQ;
      REQ: begin
        tag_trap_req_o = 1'b1;
        halt_ex_o      = 1'b1;
        // A clear arriving with the ack is dropped; ack alone decides the exit.
        if (tag_trap_ack_i) state_next = HELD;
      end
      HELD: if (tag_clear_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the record is reset explicitly because its outputs are architecturally visible as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_trap_pc_o    <= '0;
      tag_trap_instr_o <= '0;
      tag_trap_cause_o <= '0;
    end else if (capture) begin
      tag_trap_pc_o    <= pc_ex_i;
      tag_trap_instr_o <= instr_ex_i;
      tag_trap_cause_o <= cause;
    end
  end

  // Clear in HELD wins over a coincident violation, which is then simply lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                tag_overflow_o <= 1'b0;
    else if (state == HELD && tag_clear_i)     tag_overflow_o <= 1'b0;
    else if (state != IDLE && violation)       tag_overflow_o <= 1'b1;
  end

`ifdef DIFT_EXC_COUNTER_EN
  logic [15:0] exc_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                exc_count <= '0;
    else if (violation && exc_count != 16'hFFFF) exc_count <= exc_count + 16'd1;
  end

  assign tag_exc_count_o = exc_count;
`else
  assign tag_exc_count_o = '0;
`endif

endmodule
